// File: rtl/tick_counter.sv
// Up/down counter with programmable modulus, wrap/saturate and terminal pulse, stepped by an internal tick.
// Define TICK_COUNTER_PRESCALE_EN for the CLK_HZ/TICK_HZ prescaler; otherwise tick is en registered.
module tick_counter #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 1,
  parameter int WIDTH   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             sat,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             term
);

  localparam int DIV = CLK_HZ / TICK_HZ;

  if (DIV < 1 || (CLK_HZ % TICK_HZ) != 0) begin : g_bad_div
    $error("tick_counter: CLK_HZ/TICK_HZ must be an integer >= 1");
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic             tick_q, tick_d;
  logic             term_q, term_d;
  logic             step;

`ifdef TICK_COUNTER_PRESCALE_EN
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

  logic [PRE_W-1:0] pre_q, pre_d;

  always_comb begin
    pre_d  = pre_q;
    tick_d = 1'b0;
    if (en) begin
      if (pre_q == PRE_LAST) begin
        pre_d  = '0;
        tick_d = 1'b1;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) pre_q <= '0;
    else     pre_q <= pre_d;
  end
`else
  always_comb tick_d = en;
`endif

  // A registered tick is only consumed if en is still high; load overrides the step.
  assign step = tick_q & en;

  always_comb begin
    count_d = count_q;
    term_d  = 1'b0;
    if (load_en) begin
      count_d = load_val;
    end else if (step) begin
      if (up_dn) begin
        if (count_q >= max_val) begin
          term_d = 1'b1;
          if (!sat) count_d = '0;
        end else begin
          count_d = count_q + 1'b1;
        end
      end else begin
        if (count_q == '0) begin
          term_d = 1'b1;
          if (!sat) count_d = max_val;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      tick_q  <= 1'b0;
      term_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
      term_q  <= term_d;
    end
  end

  assign count = count_q;
  assign tick  = tick_q;
  assign term  = term_q;

endmodule
